// File: rtl/mem_access_stage.sv
// Memory-access stage: issues load/store on the req/ack bus, holds the flags register,
// and hands one result per instruction to writeback. Optional MEM_ALIGN_CHECK_EN adds misalign_err.
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_flags,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_cmp,
    input  logic [3:0]  rd,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  flags_q,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    state_t      state, next_state;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]  rd_q;
    logic        load_q, store_q, wb_we_q, bus_err_q;
    logic        accept, mem_op, misaligned, timeout;

    assign accept  = in_valid && (state == IDLE);
    assign mem_op  = is_load || is_store;
    assign timeout = (cnt == LAST_CNT);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;
    assign misaligned   = mem_op && (alu_result[1:0] != 2'b00);
    assign misalign_err = misalign_q;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (mem_op && !misaligned) ? ACCESS : WB;
            ACCESS:  if (mem_ack || timeout) next_state = WB;
            WB:      if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            rd_q      <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            bus_err_q <= 1'b0;
            flags_q   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: if (accept) begin
                    addr_q  <= alu_result;
                    wdata_q <= store_data;
                    rd_q    <= rd;
                    load_q  <= is_load;
                    // load wins when both are set
                    store_q <= is_store && !is_load;
                    if (is_cmp) flags_q <= alu_flags;
                    if (mem_op) begin
                        wb_we_q   <= 1'b0;
                        wb_data_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        misalign_q <= misaligned;
`endif
                    end else begin
                        wb_we_q   <= !is_cmp;
                        wb_data_q <= alu_result;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack) begin
                        cnt       <= '0;
                        wb_we_q   <= load_q;
                        wb_data_q <= load_q ? mem_rdata : 32'd0;
                    end else if (timeout) begin
                        cnt       <= '0;
                        bus_err_q <= 1'b1;
                        wb_we_q   <= 1'b0;
                        wb_data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == ACCESS);
    assign mem_we    = store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign out_valid = (state == WB);
    assign wb_we     = wb_we_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected writeback results are queued at issue
// and checked by an independent monitor on each retire handshake.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] alu_result, store_data;
    logic [1:0]  alu_flags, flags_q;
    logic        is_load, is_store, is_cmp;
    logic [3:0]  rd, wb_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic        out_valid, out_ready, wb_we, bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    mem_access_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .is_load(is_load),
        .is_store(is_store), .is_cmp(is_cmp), .rd(rd), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags_q(flags_q),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [3:0] r, input logic [31:0] d, input bit cd);
        exp_t e;
        e.we = we; e.rd = r; e.data = d; e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    // monitor: every retire handshake must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("wb_rd", {28'd0, wb_rd}, {28'd0, e.rd});
                if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [3:0] r, input logic [31:0] sd,
                         input logic ld, input logic st, input logic cmp, input logic [1:0] fl);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        alu_result = a; rd = r; store_data = sd;
        is_load = ld; is_store = st; is_cmp = cmp; alu_flags = fl;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // n cycles of mem_req with fixed bus fields, then an optional ack pulse with rdata
    task automatic mem_phase(input int n, input logic ack, input logic [31:0] rdat,
                             input logic we, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, we});
            chk("mem_addr", mem_addr, addr);
            if (we) chk("mem_wdata", mem_wdata, wd);
            chk("bus_err_early", {31'd0, bus_err}, 32'd0);
        end
        if (ack) begin
            mem_ack = 1'b1; mem_rdata = rdat;
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_rdata = 32'd0;
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {27'd0, mem_req, mem_we, out_valid, wb_we, bus_err}, 32'd0);
        chk("rst_bus", mem_addr | mem_wdata | wb_data, 32'd0);
        chk("rst_rd_flags", {26'd0, wb_rd, flags_q}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0; alu_flags = '0;
        is_load = 1'b0; is_store = 1'b0; is_cmp = 1'b0; rd = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_state();

        // ALU pass-through: one-cycle latency, no memory traffic
        push(1'b1, 4'd3, 32'h10, 1'b1);
        issue(32'h10, 4'd3, 32'd0, 0, 0, 0, 2'b00);
        @(negedge clk);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_no_req", {31'd0, mem_req}, 32'd0);

        // load, ack on third request cycle
        push(1'b1, 4'd5, 32'hDEADBEEF, 1'b1);
        issue(32'h100, 4'd5, 32'd0, 1, 0, 0, 2'b00);
        mem_phase(3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 32'd0);
        @(negedge clk);
        chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
        chk("ld_valid", {31'd0, out_valid}, 32'd1);

        // store, ack on first request cycle
        push(1'b0, 4'd7, 32'd0, 1'b1);
        issue(32'h204, 4'd7, 32'h1234, 0, 1, 0, 2'b11);
        mem_phase(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h204, 32'h1234);
        @(negedge clk);
        chk("st_valid", {31'd0, out_valid}, 32'd1);
        chk("st_flags", {30'd0, flags_q}, 32'd0);

        // cmp latches flags, following add leaves them alone
        push(1'b0, 4'd2, 32'h1, 1'b1);
        issue(32'h1, 4'd2, 32'd0, 0, 0, 1, 2'b10);
        @(negedge clk);
        chk("cmp_flags", {30'd0, flags_q}, 32'd2);
        push(1'b1, 4'd4, 32'h55, 1'b1);
        issue(32'h55, 4'd4, 32'd0, 0, 0, 0, 2'b01);
        @(negedge clk);
        chk("add_flags_kept", {30'd0, flags_q}, 32'd2);

        // load with no ack: request held 4 cycles then abort with bus_err
        push(1'b0, 4'd6, 32'd0, 1'b0);
        issue(32'h300, 4'd6, 32'd0, 1, 0, 0, 2'b00);
        mem_phase(4, 1'b0, 32'd0, 1'b0, 32'h300, 32'd0);
        @(negedge clk);
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_valid", {31'd0, out_valid}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);
        chk("late_ack_ignored", {30'd0, mem_req, out_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // writeback stall then reset
        out_ready = 1'b0;
        issue(32'hABCD, 4'd9, 32'd0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_wb", {wb_data[26:0], wb_rd, wb_we}, {27'hABCD, 4'd9, 1'b1});
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_reset_state();

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
